// File: rtl/serial_twos_negator_pkg.sv
// rtl/serial_twos_negator_pkg.sv - shared constants for the serial two's complement negator
package serial_twos_negator_pkg;

   // Operand width used unless the instantiating block overrides it
   localparam int DEFAULT_WIDTH = 32;

   // Controller state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Bit counter width; a one-bit operand still needs a one-bit counter
   function automatic int cnt_bits(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_negate_bit.sv
// rtl/serial_negate_bit.sv - one-bit combinational stage of the serial negator
module serial_negate_bit (
   input  logic x_i,
   input  logic carry,
   input  logic negate,
   output logic bit_out,
   output logic carry_next
);

   // Invert-and-add-one, one bit at a time; pass-through keeps the carry untouched
   always_comb begin
      bit_out    = x_i;
      carry_next = carry;
      if (negate) begin
         bit_out    = ~x_i ^ carry;
         carry_next = ~x_i & carry;
      end
   end

endmodule

// File: rtl/serial_twos_negator.sv
// rtl/serial_twos_negator.sv - bit-serial two's complement negate / pass-through unit
module serial_twos_negator
   import serial_twos_negator_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_negate,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_overflow,
   output logic             busy
);

   localparam int CW = cnt_bits(WIDTH);

   logic [1:0]       state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             negate_q;
   logic             bit_out;
   logic             carry_next;
   logic             last_shift;
   logic             handshake;

   assign in_ready   = (state == ST_IDLE);
   assign busy       = (state == ST_SHIFT) || (state == ST_DONE);
   assign last_shift = (cnt == CW'(WIDTH - 1));
   // out_valid is a flop that rises one cycle into DONE, so the consumer
   // sees a result that has settled for a full cycle before it can take it
   assign handshake  = (state == ST_DONE) && out_valid && out_ready;

   serial_negate_bit u_bit (
      .x_i        (sreg[0]),
      .carry      (carry),
      .negate     (negate_q),
      .bit_out    (bit_out),
      .carry_next (carry_next)
   );

   // Controller, operand shifter and result accumulator
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         sreg         <= '0;
         cnt          <= '0;
         carry        <= 1'b0;
         negate_q     <= 1'b0;
         out_data     <= '0;
         out_overflow <= 1'b0;
         out_valid    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               out_valid <= 1'b0;
               if (in_valid) begin
                  sreg         <= in_data;
                  negate_q     <= in_negate;
                  cnt          <= '0;
                  carry        <= 1'b1;
                  out_overflow <= 1'b0;
                  state        <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               sreg     <= sreg >> 1;
               out_data <= {bit_out, out_data[WIDTH-1:1]};
               carry    <= carry_next;
               cnt      <= cnt + 1'b1;
               if (last_shift) begin
                  // Carry still set at the MSB means every lower bit was zero,
                  // so a set MSB here is the most negative value
                  out_overflow <= negate_q & carry & sreg[0];
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (handshake) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_twos_negator.sv
// tb/tb_serial_twos_negator.sv - randomized self-checking bench for serial_twos_negator
module tb_serial_twos_negator;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         in_negate = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_overflow;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;

   serial_twos_negator #(.WIDTH(W)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_negate    (in_negate),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_overflow (out_overflow),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: arithmetic negation modulo 2^W; overflow when a nonzero value negates to itself
   function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic neg);
      logic [W-1:0] r;
      logic         ovf;
      r   = neg ? W'(0 - x) : x;
      ovf = neg && (x != 0) && (r == x);
      return {ovf, r};
   endfunction

   task automatic do_op(input logic [W-1:0] d, input logic neg, input int hold, input bit junk);
      logic [W:0] e;
      int         lat;
      e   = ref_model(d, neg);
      lat = 0;
      while (!in_ready && lat < 100) begin
         @(negedge clock);
         lat++;
      end
      check("in_ready_idle", in_ready, 1);
      in_valid  = 1'b1;
      in_data   = d;
      in_negate = neg;
      @(posedge clock);
      lat = 0;
      @(negedge clock);
      if (!junk) in_valid = 1'b0;
      while (!out_valid && lat < 100) begin
         if (lat == 5) begin
            check("in_ready_shift", in_ready, 0);
            check("busy_shift", busy, 1);
         end
         if (junk) begin
            in_data   = $urandom;
            in_negate = $urandom_range(0, 1);
         end
         out_ready = $urandom_range(0, 1);
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("latency", lat, W + 1);
      check("out_data", out_data, e[W-1:0]);
      check("out_overflow", out_overflow, e[W]);
      for (int i = 0; i < hold; i++) begin
         @(posedge clock);
         @(negedge clock);
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, e[W-1:0]);
         check("hold_ovf", out_overflow, e[W]);
      end
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      out_ready = 1'b0;
      check("ret_in_ready", in_ready, 1);
      check("ret_valid", out_valid, 0);
      check("ret_busy", busy, 0);
      check("idle_data_held", out_data, e[W-1:0]);
   endtask

   task automatic reset_mid_shift();
      int lat;
      lat = 0;
      while (!in_ready && lat < 100) begin
         @(negedge clock);
         lat++;
      end
      in_valid  = 1'b1;
      in_data   = 32'h1234_5678;
      in_negate = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (12) @(posedge clock);
      @(negedge clock);
      check("busy_before_reset", busy, 1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("rst_out_data", out_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_ovf", out_overflow, 0);
   endtask

   initial begin
      logic [W-1:0] d;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_ovf", out_overflow, 0);
      check("reset_busy", busy, 0);
      reset = 1'b0;
      @(negedge clock);

      do_op(32'h0000_0005, 1'b1, 0, 1'b0);
      do_op(32'h8000_0000, 1'b1, 0, 1'b0);
      do_op(32'h0000_0000, 1'b1, 0, 1'b0);
      do_op(32'hDEAD_BEEF, 1'b0, 0, 1'b1);
      do_op(32'h0000_0001, 1'b1, 10, 1'b0);
      reset_mid_shift();
      do_op(32'hFFFF_FFFF, 1'b1, 0, 1'b0);
      do_op(32'h8000_0000, 1'b0, 1, 1'b0);

      for (int k = 0; k < 20; k++) begin
         case ($urandom_range(0, 5))
            0:       d = 32'h8000_0000;
            1:       d = '0;
            2:       d = 32'h8000_0001;
            default: d = $urandom;
         endcase
         do_op(d, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_twos_negator.md
SERIAL_TWOS_NEGATOR -- requirements
Module: serial_twos_negator

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width in bits.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  the producer offers an operand.
REQ-005 SHALL have port in_ready  output  1  the block can accept an operand.
REQ-006 SHALL have port in_data  input  WIDTH  the operand, in two's complement.
REQ-007 SHALL have port in_negate  input  1  1 = produce -in_data; 0 = pass in_data through.
REQ-008 SHALL have port out_valid  output  1  a result is held on out_data.
REQ-009 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-010 SHALL have port out_data  output  WIDTH  the result.
REQ-011 SHALL have port out_overflow  output  1  set when negating the most negative value (1 followed by WIDTH-1 zeros).
REQ-012 SHALL have port busy  output  1  high in SHIFT and DONE.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT, and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL, on an accept (IDLE, in_valid=1), latch in_data into the shift register, latch in_negate, clear the bit counter, set carry=1 and clear out_overflow, then enter SHIFT.
REQ-016 SHALL, in SHIFT, process one bit per cycle, LSB first:
- if negate: bit = ~x_i XOR carry, and carry_next = ~x_i AND carry;
- otherwise: bit = x_i.
REQ-017 SHALL shift each result bit in at the MSB end of the result register, so that after WIDTH shifts out_data is aligned with bit 0 at the LSB.
REQ-018 SHALL leave SHIFT for DONE after exactly WIDTH SHIFT cycles, i.e. when the counter reaches WIDTH-1.
REQ-019 SHALL give a latency of WIDTH+1 cycles: with the accept at edge 0, out_valid rises after edge WIDTH+1.
REQ-020 SHALL, in DONE, hold out_valid=1 and keep out_data and out_overflow stable until out_ready=1.
REQ-021 SHALL, on a DONE cycle with out_ready=1, return to IDLE, and SHALL NOT accept a new operand in that same cycle.
REQ-022 SHALL set out_overflow=1 iff negate=1, the operand MSB=1, and all lower operand bits=0, in which case out_data equals the operand.
REQ-023 SHALL produce 0 with out_overflow=0 when negating 0 (the final carry out is discarded).
REQ-024 SHALL ignore in_valid, in_data and in_negate while in SHIFT or DONE.
REQ-025 SHALL ignore out_ready outside DONE.
REQ-026 SHALL change out_data only in SHIFT; out_data SHALL hold its last value in IDLE.

Reset
REQ-027 SHALL, while reset=1 on a clock edge, go to IDLE and clear out_data, out_overflow, out_valid, busy, the counter and carry, with in_ready=1 on the following cycle.
REQ-028 SHALL give reset priority over every other event, abort any operation in progress during SHIFT or DONE, and discard its partial result.

Structure
REQ-029 SHALL take the state encoding (IDLE/SHIFT/DONE) and the default WIDTH constant from the processor-wide shared package.
REQ-030 SHALL instantiate one sub-module, serial_negate_bit: a combinational one-bit stage with inputs x_i, carry, negate and outputs bit, carry_next.
REQ-031 SHALL size the bit counter as clog2(WIDTH) bits.

Verification
REQ-032 SHALL be checked with: in_data=0x00000005, in_negate=1 -> out_data=0xFFFFFFFB, out_overflow=0, out_valid first high 33 cycles after the accept.
REQ-033 SHALL be checked with: in_data=0x80000000, in_negate=1 -> out_data=0x80000000, out_overflow=1; and in_data=0x00000000, in_negate=1 -> out_data=0x00000000, out_overflow=0.
REQ-034 SHALL be checked with: in_data=0xDEADBEEF, in_negate=0 -> out_data=0xDEADBEEF; in_valid held high with changing in_data during SHIFT -> result unaffected and in_ready=0.
REQ-035 SHALL be checked with: out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable; out_ready=1 -> IDLE next cycle and in_ready=1 one cycle after the handshake.
REQ-036 SHALL be checked with: reset asserted at SHIFT cycle 12 -> next cycle IDLE, out_data=0, out_valid=0, in_ready=1; a new operand 0xFFFFFFFF with negate=1 -> out_data=0x00000001.
